// File: rtl/reg_cmd_frame_decoder.sv
// Host-link register-write frame decoder: SYNC, ADDR, D0, D1, D2, CSUM.
// Emits one register write per good frame; reports checksum/reserved/timeout aborts.
module reg_cmd_frame_decoder #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TMO_W          = 16
) (
  input  logic        sysClk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_valid,
  output logic [7:0]  reg_addr,
  output logic [16:0] reg_data,
  output logic        reg_input_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] good_frame_cnt,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_D0, S_D1, S_D2, S_CSUM
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state, w_state;
  logic [TMO_W-1:0] r_tmo, w_tmo;
  logic [7:0]       r_sum, w_sum;
  logic [7:0]       r_addr, w_addr;
  logic [7:0]       r_d0, w_d0;
  logic [7:0]       r_d1, w_d1;
  logic             r_d2b, w_d2b;
  logic             r_rsvd, w_rsvd;
  logic             w_good;
  logic             w_err;
  logic [1:0]       w_code;
  logic [7:0]       w_total;

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tmo   <= '0;
      r_sum   <= '0;
      r_addr  <= '0;
      r_d0    <= '0;
      r_d1    <= '0;
      r_d2b   <= 1'b0;
      r_rsvd  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tmo   <= w_tmo;
      r_sum   <= w_sum;
      r_addr  <= w_addr;
      r_d0    <= w_d0;
      r_d1    <= w_d1;
      r_d2b   <= w_d2b;
      r_rsvd  <= w_rsvd;
    end
  end

  assign w_total = r_sum + byte_in;

  always_comb begin
    w_state = r_state;
    w_tmo   = r_tmo;
    w_sum   = r_sum;
    w_addr  = r_addr;
    w_d0    = r_d0;
    w_d1    = r_d1;
    w_d2b   = r_d2b;
    w_rsvd  = r_rsvd;
    w_good  = 1'b0;
    w_err   = 1'b0;
    w_code  = err_code;
    if (r_state == S_IDLE) begin
      w_tmo = '0;
      if (byte_in_valid && byte_in == SYNC_BYTE) begin
        w_state = S_ADDR;
        w_sum   = '0;
        w_rsvd  = 1'b0;
      end
    end else if (byte_in_valid) begin
      w_tmo = '0;
      case (r_state)
        S_ADDR: begin
          w_addr  = byte_in;
          w_sum   = byte_in;
          w_state = S_D0;
        end
        S_D0: begin
          w_d0    = byte_in;
          w_sum   = w_total;
          w_state = S_D1;
        end
        S_D1: begin
          w_d1    = byte_in;
          w_sum   = w_total;
          w_state = S_D2;
        end
        S_D2: begin
          w_d2b   = byte_in[0];
          w_rsvd  = |byte_in[7:1];
          w_sum   = w_total;
          w_state = S_CSUM;
        end
        S_CSUM: begin
          w_state = S_IDLE;
          // Reserved-bit violation is reported ahead of a checksum mismatch.
          if (r_rsvd) begin
            w_err  = 1'b1;
            w_code = 2'd2;
          end else if (w_total != 8'h00) begin
            w_err  = 1'b1;
            w_code = 2'd1;
          end else begin
            w_good = 1'b1;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end else if (r_tmo == TMO_LAST) begin
      w_state = S_IDLE;
      w_tmo   = '0;
      w_err   = 1'b1;
      w_code  = 2'd3;
    end else begin
      w_tmo = r_tmo + TMO_W'(1);
    end
  end

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      reg_addr        <= '0;
      reg_data        <= '0;
      reg_input_valid <= 1'b0;
      frame_err       <= 1'b0;
      err_code        <= '0;
      good_frame_cnt  <= '0;
      err_cnt         <= '0;
    end else begin
      reg_input_valid <= w_good;
      frame_err       <= w_err;
      if (w_good) begin
        reg_addr       <= r_addr;
        reg_data       <= {r_d2b, r_d1, r_d0};
        good_frame_cnt <= good_frame_cnt + 16'd1;
      end
      if (w_err) begin
        err_code <= w_code;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_cmd_frame_decoder.sv
// Randomized and directed bench for reg_cmd_frame_decoder against a queue-based frame model.
module tb_reg_cmd_frame_decoder;

  localparam int TMO = 16;

  logic        sysClk = 1'b0;
  logic        reset  = 1'b1;
  logic [7:0]  byte_in = '0;
  logic        byte_in_valid = 1'b0;
  logic [7:0]  reg_addr;
  logic [16:0] reg_data;
  logic        reg_input_valid;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] good_frame_cnt;
  logic [7:0]  err_cnt;

  reg_cmd_frame_decoder #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TMO),
    .TMO_W          (16)
  ) dut (
    .sysClk          (sysClk),
    .reset           (reset),
    .byte_in         (byte_in),
    .byte_in_valid   (byte_in_valid),
    .reg_addr        (reg_addr),
    .reg_data        (reg_data),
    .reg_input_valid (reg_input_valid),
    .frame_err       (frame_err),
    .err_code        (err_code),
    .good_frame_cnt  (good_frame_cnt),
    .err_cnt         (err_cnt)
  );

  always #5 sysClk = ~sysClk;

  int tests_run = 0;
  int tests_failed = 0;

  int          mq[$];
  int          m_idle;
  logic [7:0]  m_addr;
  logic [16:0] m_data;
  logic [1:0]  m_code;
  logic [15:0] m_good;
  logic [7:0]  m_errs;
  logic        e_valid, e_err;
  int          n_valid, n_err, n_mismatch;

  task automatic model_reset();
    mq.delete();
    m_idle = 0; m_addr = '0; m_data = '0; m_code = '0;
    m_good = '0; m_errs = '0; e_valid = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_abort(input logic [1:0] code);
    e_err  = 1'b1;
    m_code = code;
    if (m_errs != 8'hFF) m_errs = m_errs + 8'd1;
    mq.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    int s;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (mq.size() == 0) begin
      if (v && b == 8'hA5) begin
        mq.push_back(int'(b));
        m_idle = 0;
      end
    end else if (v) begin
      mq.push_back(int'(b));
      m_idle = 0;
      if (mq.size() == 6) begin
        s = (mq[1] + mq[2] + mq[3] + mq[4] + mq[5]) % 256;
        if ((mq[4] / 2) != 0) model_abort(2'd2);
        else if (s != 0)      model_abort(2'd1);
        else begin
          e_valid = 1'b1;
          m_addr  = 8'(mq[1]);
          m_data  = 17'((mq[4] % 2) * 65536 + mq[3] * 256 + mq[2]);
          m_good  = m_good + 16'd1;
          mq.delete();
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) model_abort(2'd3);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] b);
    @(negedge sysClk);
    byte_in_valid = v;
    byte_in       = b;
    @(posedge sysClk);
    #1;
    model_step(v, b);
    if (reg_input_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_err++;
    if (reg_input_valid !== e_valid || frame_err !== e_err || reg_addr !== m_addr ||
        reg_data !== m_data || err_code !== m_code || good_frame_cnt !== m_good ||
        err_cnt !== m_errs)
      n_mismatch++;
  endtask

  task automatic send6(input logic [7:0] a, b, c, d, e, f);
    cycle(1'b1, a); cycle(1'b1, b); cycle(1'b1, c);
    cycle(1'b1, d); cycle(1'b1, e); cycle(1'b1, f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge sysClk);
    reset = 1'b1;
    byte_in_valid = 1'b0;
    @(posedge sysClk);
    #1;
    model_reset();
    @(negedge sysClk);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    tests_run++;
    if (reg_addr !== 8'h00 || reg_data !== 17'h0 || reg_input_valid !== 1'b0 ||
        frame_err !== 1'b0 || err_code !== 2'd0 || good_frame_cnt !== 16'h0 ||
        err_cnt !== 8'h00) begin
      tests_failed++;
      $display("FAIL %s: outputs addr=%h data=%h v=%b e=%b code=%0d good=%0d errs=%0d, required all 0",
               tag, reg_addr, reg_data, reg_input_valid, frame_err, err_code, good_frame_cnt, err_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_all_zero("reset_state");
    idle(3);
    tests_run++;
    if (n_mismatch !== 0) begin
      tests_failed++;
      $display("FAIL reset_idle_model: mismatches=%0d required 0", n_mismatch);
    end
  endtask

  task automatic test_good_frame();
    int v0 = n_valid, e0 = n_err;
    send6(8'hA5, 8'h10, 8'h34, 8'h12, 8'h01, 8'hA9);
    tests_run++;
    if (reg_input_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL good_pulse: valid=%b required 1", reg_input_valid);
    end
    idle(2);
    tests_run++;
    if (reg_addr !== 8'h10) begin
      tests_failed++;
      $display("FAIL good_addr: got %h required 10", reg_addr);
    end
    tests_run++;
    if (reg_data !== 17'h11234) begin
      tests_failed++;
      $display("FAIL good_data: got %h required 11234", reg_data);
    end
    tests_run++;
    if (good_frame_cnt !== 16'd1 || n_valid - v0 !== 1 || n_err - e0 !== 0) begin
      tests_failed++;
      $display("FAIL good_counts: cnt=%0d pulses=%0d errs=%0d required 1/1/0",
               good_frame_cnt, n_valid - v0, n_err - e0);
    end
  endtask

  task automatic test_checksum_err();
    int v0 = n_valid;
    send6(8'hA5, 8'h10, 8'h34, 8'h12, 8'h01, 8'hAA);
    tests_run++;
    if (frame_err !== 1'b1 || err_code !== 2'd1) begin
      tests_failed++;
      $display("FAIL csum_err: err=%b code=%0d required 1/1", frame_err, err_code);
    end
    idle(2);
    tests_run++;
    if (err_cnt !== 8'd1 || n_valid - v0 !== 0 || reg_addr !== 8'h10 || reg_data !== 17'h11234) begin
      tests_failed++;
      $display("FAIL csum_state: errs=%0d pulses=%0d addr=%h data=%h required 1/0/10/11234",
               err_cnt, n_valid - v0, reg_addr, reg_data);
    end
  endtask

  task automatic test_reserved_bits();
    send6(8'hA5, 8'h10, 8'h34, 8'h12, 8'h03, 8'hA7);
    tests_run++;
    if (frame_err !== 1'b1 || err_code !== 2'd2 || err_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL rsvd_err: err=%b code=%0d errs=%0d required 1/2/2", frame_err, err_code, err_cnt);
    end
    send6(8'hA5, 8'h10, 8'h34, 8'h12, 8'h03, 8'h00);
    tests_run++;
    if (err_code !== 2'd2) begin
      tests_failed++;
      $display("FAIL rsvd_precedence: code=%0d required 2", err_code);
    end
    idle(1);
  endtask

  task automatic test_timeout();
    int e0;
    cycle(1'b1, 8'hA5); cycle(1'b1, 8'h10);
    idle(TMO - 1);
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_early: err=%b required 0", frame_err);
    end
    idle(1);
    tests_run++;
    if (frame_err !== 1'b1 || err_code !== 2'd3) begin
      tests_failed++;
      $display("FAIL timeout_err: err=%b code=%0d required 1/3", frame_err, err_code);
    end
    send6(8'hA5, 8'h20, 8'h00, 8'h00, 8'h00, 8'hE0);
    tests_run++;
    if (reg_input_valid !== 1'b1 || reg_addr !== 8'h20 || reg_data !== 17'h0) begin
      tests_failed++;
      $display("FAIL after_timeout: v=%b addr=%h data=%h required 1/20/0", reg_input_valid, reg_addr, reg_data);
    end
    e0 = n_err;
    cycle(1'b1, 8'hA5); cycle(1'b1, 8'h10);
    idle(TMO - 1);
    cycle(1'b1, 8'h34); cycle(1'b1, 8'h12); cycle(1'b1, 8'h01); cycle(1'b1, 8'hA9);
    tests_run++;
    if (reg_input_valid !== 1'b1 || n_err !== e0) begin
      tests_failed++;
      $display("FAIL timeout_edge_byte: v=%b new_errs=%0d required 1/0", reg_input_valid, n_err - e0);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int v0;
    do_reset();
    v0 = n_valid;
    cycle(1'b1, 8'h00); cycle(1'b1, 8'hFF); cycle(1'b1, 8'h5A);
    send6(8'hA5, 8'h10, 8'h34, 8'h12, 8'h01, 8'hA9);
    send6(8'hA5, 8'h10, 8'h34, 8'h12, 8'h01, 8'hA9);
    idle(2);
    tests_run++;
    if (n_valid - v0 !== 2 || good_frame_cnt !== 16'd2 || err_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL back_to_back: pulses=%0d good=%0d errs=%0d required 2/2/0",
               n_valid - v0, good_frame_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int v0;
    cycle(1'b1, 8'hA5); cycle(1'b1, 8'h10); cycle(1'b1, 8'h34); cycle(1'b1, 8'h12);
    v0 = n_valid;
    do_reset();
    check_all_zero("midframe_reset");
    idle(2);
    send6(8'hA5, 8'h10, 8'h34, 8'h12, 8'h01, 8'hA9);
    tests_run++;
    if (reg_input_valid !== 1'b1 || good_frame_cnt !== 16'd1 || n_valid - v0 !== 1) begin
      tests_failed++;
      $display("FAIL midframe_recover: v=%b good=%0d pulses=%0d required 1/1/1",
               reg_input_valid, good_frame_cnt, n_valid - v0);
    end
    idle(1);
  endtask

  task automatic test_random();
    logic [7:0] f[6];
    int sum, stop_at;
    for (int k = 0; k < 60; k++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        if ($urandom_range(0, 1) == 1) begin
          f[0] = 8'($urandom);
          if (f[0] == 8'hA5) f[0] = 8'h00;
          cycle(1'b1, f[0]);
        end else cycle(1'b0, 8'h00);
      end
      f[0] = 8'hA5;
      f[1] = 8'($urandom); f[2] = 8'($urandom); f[3] = 8'($urandom);
      f[4] = 8'($urandom_range(0, 1));
      sum = (f[1] + f[2] + f[3] + f[4]) % 256;
      f[5] = 8'((256 - sum) % 256);
      case ($urandom_range(0, 7))
        0: f[5] = f[5] + 8'(1 + $urandom_range(0, 254));
        1: f[4] = f[4] | 8'(2 << $urandom_range(0, 6));
        default: ;
      endcase
      stop_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 5) : 6;
      for (int i = 0; i < 6; i++) begin
        if (i == stop_at) begin
          idle(TMO + $urandom_range(0, 2));
          break;
        end
        if (i > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, TMO - 1));
        cycle(1'b1, f[i]);
      end
    end
    idle(TMO + 2);
    tests_run++;
    if (n_mismatch !== 0) begin
      tests_failed++;
      $display("FAIL random_model: mismatching cycles=%0d required 0", n_mismatch);
    end
    tests_run++;
    if (good_frame_cnt !== m_good || err_cnt !== m_errs) begin
      tests_failed++;
      $display("FAIL random_counts: good=%0d errs=%0d required %0d/%0d", good_frame_cnt, err_cnt, m_good, m_errs);
    end
  endtask

  task automatic test_err_saturate();
    for (int k = 0; k < 260; k++) send6(8'hA5, 8'h10, 8'h34, 8'h12, 8'h01, 8'hAA);
    idle(2);
    tests_run++;
    if (err_cnt !== 8'hFF) begin
      tests_failed++;
      $display("FAIL err_saturate: got %h required FF", err_cnt);
    end
    tests_run++;
    if (n_mismatch !== 0) begin
      tests_failed++;
      $display("FAIL final_model: mismatching cycles=%0d required 0", n_mismatch);
    end
  endtask

  initial begin
    n_valid = 0; n_err = 0; n_mismatch = 0;
    model_reset();
    test_reset();
    test_good_frame();
    test_checksum_err();
    test_reserved_bits();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    test_err_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
